// File: rtl/hci_core_source_credit.sv
// -----------------------------------------------------------------------------
// hci_core_source_credit
//  Credit-based linear load streamer. It walks base/stride/len over an HCI-Core
//  initiator port, keeps up to MAX_OUTSTANDING loads in flight and turns the
//  responses into an aligned HWPE-Stream. Responses are always accepted
//  (r_ready is tied high) because every granted load already owns a slot in
//  the response buffer.
//
//  Ports
//   clk_i, rst_ni                 clock, async active-low reset
//   clear_i                       sync soft clear (flushes everything)
//   enable_i                      gates FSM, issue and stream (not capture)
//   req_start_i, base_addr_i,
//   stride_i, tot_len_i           transfer command, sampled in IDLE
//   ready_start_o, done_o         idle flag, end-of-transfer pulse
//   outstanding_o                 granted-but-unconsumed loads
//   tcdm_*                        HCI-Core load port
//   stream_*                      HWPE-Stream output
// -----------------------------------------------------------------------------
module hci_core_source_credit #(
    parameter int unsigned DW              = 32,
    parameter int unsigned AW              = 32,
    parameter int unsigned MAX_OUTSTANDING = 4,
    parameter int unsigned TRANS_CNT       = 16,
    parameter int unsigned MISALIGNED      = 1,
    localparam int unsigned TDW            = DW + ((MISALIGNED != 0) ? 32 : 0),
    localparam int unsigned OCW            = $clog2(MAX_OUTSTANDING + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 clear_i,
    input  logic                 enable_i,
    input  logic                 req_start_i,
    input  logic [AW-1:0]        base_addr_i,
    input  logic [AW-1:0]        stride_i,
    input  logic [TRANS_CNT-1:0] tot_len_i,
    output logic                 ready_start_o,
    output logic                 done_o,
    output logic [OCW-1:0]       outstanding_o,
    output logic                 tcdm_req_o,
    input  logic                 tcdm_gnt_i,
    output logic [AW-1:0]        tcdm_add_o,
    output logic                 tcdm_wen_o,
    input  logic                 tcdm_r_valid_i,
    input  logic [TDW-1:0]       tcdm_r_data_i,
    output logic                 tcdm_r_ready_o,
    output logic                 stream_valid_o,
    output logic [DW-1:0]        stream_data_o,
    output logic [DW/8-1:0]      stream_strb_o,
    input  logic                 stream_ready_i
);

    localparam int unsigned PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam logic [OCW-1:0] MO = OCW'(MAX_OUTSTANDING);

    typedef enum logic [1:0] {IDLE, WORKING, DRAIN} state_e;

    state_e               state_q, state_d;
    logic [AW-1:0]        addr_q, stride_q;
    logic [TRANS_CNT-1:0] len_q, issued_q, consumed_q;
    logic [OCW-1:0]       outstanding_q, drop_q, resp_cnt_q;
    logic [PW-1:0]        resp_wptr_q, resp_rptr_q, off_wptr_q, off_rptr_q;
    logic [TDW-1:0]       resp_mem [MAX_OUTSTANDING];
    logic [1:0]           off_mem  [MAX_OUTSTANDING];

    logic                 issue_fire, pop, resp_push, drop_hit, start_fire;
    logic [OCW:0]         pend_at_clear;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(MAX_OUTSTANDING - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [DW-1:0] realign(input logic [TDW-1:0] w, input logic [1:0] off);
        logic [TDW-1:0] s;
        s = w >> {off, 3'b000};
        return s[DW-1:0];
    endfunction

    assign tcdm_req_o     = enable_i && (state_q == WORKING) && (issued_q < len_q)
                            && (outstanding_q < MO) && (drop_q == '0);
    assign tcdm_add_o     = {addr_q[AW-1:2], 2'b00};
    assign tcdm_wen_o     = 1'b1;
    assign tcdm_r_ready_o = 1'b1;

    assign issue_fire = tcdm_req_o & tcdm_gnt_i;
    assign pop        = stream_valid_o & stream_ready_i;
    // Responses owed to requests killed by a clear are swallowed here.
    assign resp_push  = tcdm_r_valid_i & (drop_q == '0);
    assign drop_hit   = tcdm_r_valid_i & (drop_q != '0);

    assign stream_valid_o = enable_i && (resp_cnt_q != '0);
    assign stream_data_o  = realign(resp_mem[resp_rptr_q], off_mem[off_rptr_q]);
    assign stream_strb_o  = '1;
    assign ready_start_o  = (state_q == IDLE);
    assign outstanding_o  = outstanding_q;

    // Loads the memory still owes at clear time: old debt, granted-but-not-
    // answered loads, a grant in this very cycle, minus a response arriving now.
    assign pend_at_clear = {1'b0, drop_q} + {1'b0, outstanding_q} - {1'b0, resp_cnt_q}
                           + (OCW+1)'(issue_fire) - (OCW+1)'(tcdm_r_valid_i);

    always_comb begin
        state_d    = state_q;
        done_o     = 1'b0;
        start_fire = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (req_start_i) begin
                    if (tot_len_i == '0) begin
                        done_o = 1'b1;
                    end else if (enable_i) begin
                        state_d    = WORKING;
                        start_fire = 1'b1;
                    end
                end
            end
            WORKING: begin
                if (issue_fire && (issued_q + 1'b1 == len_q)) state_d = DRAIN;
            end
            DRAIN: begin
                if (enable_i && (consumed_q == len_q)) begin
                    state_d = IDLE;
                    done_o  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (clear_i) begin
            state_d    = IDLE;
            done_o     = 1'b0;
            start_fire = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            stride_q      <= '0;
            len_q         <= '0;
            issued_q      <= '0;
            consumed_q    <= '0;
            outstanding_q <= '0;
            drop_q        <= '0;
            resp_cnt_q    <= '0;
            resp_wptr_q   <= '0;
            resp_rptr_q   <= '0;
            off_wptr_q    <= '0;
            off_rptr_q    <= '0;
        end else if (clear_i) begin
            state_q       <= IDLE;
            issued_q      <= '0;
            consumed_q    <= '0;
            outstanding_q <= '0;
            drop_q        <= pend_at_clear[OCW-1:0];
            resp_cnt_q    <= '0;
            resp_wptr_q   <= '0;
            resp_rptr_q   <= '0;
            off_wptr_q    <= '0;
            off_rptr_q    <= '0;
        end else begin
            state_q <= state_d;
            if (start_fire) begin
                addr_q     <= base_addr_i;
                stride_q   <= stride_i;
                len_q      <= tot_len_i;
                issued_q   <= '0;
                consumed_q <= '0;
            end else begin
                if (issue_fire) begin
                    addr_q   <= addr_q + stride_q;
                    issued_q <= issued_q + 1'b1;
                end
                if (pop) consumed_q <= consumed_q + 1'b1;
            end
            if (issue_fire && !pop)      outstanding_q <= outstanding_q + 1'b1;
            else if (!issue_fire && pop) outstanding_q <= outstanding_q - 1'b1;
            if (drop_hit) drop_q <= drop_q - 1'b1;
            if (resp_push && !pop)      resp_cnt_q <= resp_cnt_q + 1'b1;
            else if (!resp_push && pop) resp_cnt_q <= resp_cnt_q - 1'b1;
            if (resp_push)  resp_wptr_q <= ptr_inc(resp_wptr_q);
            if (pop)        resp_rptr_q <= ptr_inc(resp_rptr_q);
            if (issue_fire) off_wptr_q  <= ptr_inc(off_wptr_q);
            if (pop)        off_rptr_q  <= ptr_inc(off_rptr_q);
        end
    end

    // Buffer storage carries no reset; occupancy is tracked by the counters.
    always_ff @(posedge clk_i) begin
        if (resp_push) resp_mem[resp_wptr_q] <= tcdm_r_data_i;
        if (issue_fire) off_mem[off_wptr_q] <= (MISALIGNED != 0) ? addr_q[1:0] : 2'b00;
    end

    // The credit rule reserves a slot for every granted load.
    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     !(resp_push && !clear_i && (resp_cnt_q == MO)));

endmodule

// File: tb/tb_hci_core_source_credit.sv
module tb_hci_core_source_credit;

    localparam int MO = 4;

    logic        clk = 1'b0;
    logic        rst_n, clear, enable, req_start;
    logic [31:0] base, stride;
    logic [15:0] tot_len;
    logic        ready_start, done;
    logic [2:0]  outstanding;
    logic        tcdm_req, gnt, wen, r_valid, r_ready;
    logic [31:0] add;
    logic [63:0] r_data;
    logic        s_valid, s_ready;
    logic [31:0] s_data;
    logic [3:0]  s_strb;

    hci_core_source_credit #(
        .DW(32), .AW(32), .MAX_OUTSTANDING(MO), .TRANS_CNT(16), .MISALIGNED(1)
    ) dut (
        .clk_i(clk), .rst_ni(rst_n), .clear_i(clear), .enable_i(enable),
        .req_start_i(req_start), .base_addr_i(base), .stride_i(stride), .tot_len_i(tot_len),
        .ready_start_o(ready_start), .done_o(done), .outstanding_o(outstanding),
        .tcdm_req_o(tcdm_req), .tcdm_gnt_i(gnt), .tcdm_add_o(add), .tcdm_wen_o(wen),
        .tcdm_r_valid_i(r_valid), .tcdm_r_data_i(r_data), .tcdm_r_ready_o(r_ready),
        .stream_valid_o(s_valid), .stream_data_o(s_data), .stream_strb_o(s_strb),
        .stream_ready_i(s_ready)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] addr; int due; } pend_t;
    pend_t       pend [$];
    logic [31:0] mem [logic [31:0]];
    logic [31:0] beats [$];

    int total = 0, bad = 0;
    int cyc = 0, lat = 1, gnt_limit = 32'h7fffffff, grant_cnt = 0;
    bit gnt_rand = 0, ready_rand = 0, ready_low = 0;
    int model_out = 0, peak = 0, out_err = 0, req_full = 0, rready_low = 0;
    int req_seen = 0, done_cnt = 0, done_cyc = -1, last_hs = -1, start_cyc = 0;

    function automatic logic [31:0] rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a;
    endfunction

    // Beat = the four bytes starting at byte address a, little-endian.
    function automatic logic [31:0] exp_beat(input logic [31:0] a);
        logic [31:0] r, x, w;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            x = a + k;
            w = rd({x[31:2], 2'b00});
            r[8*k +: 8] = 8'((w >> (8 * x[1:0])) & 32'hFF);
        end
        return r;
    endfunction

    // Memory + observer: drives the memory side on the falling edge and
    // samples everything just before the rising edge.
    initial begin
        forever begin
            @(negedge clk);
            cyc++;
            if (pend.size() > 0 && pend[0].due <= cyc) begin
                r_valid = 1'b1;
                r_data  = {rd(pend[0].addr + 4), rd(pend[0].addr)};
                void'(pend.pop_front());
            end else begin
                r_valid = 1'b0;
                r_data  = '0;
            end
            gnt = gnt_rand ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (grant_cnt >= gnt_limit) gnt = 1'b0;
            s_ready = ready_low ? 1'b0 : (ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1);
            #4;
            if (rst_n) begin
                if (int'(outstanding) != model_out) out_err++;
                if (int'(outstanding) > peak) peak = int'(outstanding);
                if (tcdm_req && model_out >= MO) req_full++;
                if (!r_ready) rready_low++;
                if (tcdm_req) req_seen++;
                if (done) begin done_cnt++; done_cyc = cyc; end
                if (tcdm_req && gnt) begin
                    pend.push_back('{add, cyc + lat});
                    grant_cnt++;
                end
                if (s_valid && s_ready) begin
                    beats.push_back(s_data);
                    last_hs = cyc;
                end
                if (clear) model_out = 0;
                else model_out = model_out + int'(tcdm_req && gnt) - int'(s_valid && s_ready);
            end
        end
    end

    task automatic start_xfer(input logic [31:0] b, input logic [31:0] s, input logic [15:0] l);
        @(negedge clk); #1;
        base = b; stride = s; tot_len = l; req_start = 1'b1; start_cyc = cyc;
        @(negedge clk); #1;
        req_start = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge clk); #1;
        total++; if (ready_start !== 1'b1) begin bad++; $display("FAIL reset_ready_start: got %b want 1", ready_start); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", done); end
        total++; if (tcdm_req !== 1'b0) begin bad++; $display("FAIL reset_req: got %b want 0", tcdm_req); end
        total++; if (s_valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", s_valid); end
        total++; if (outstanding !== 3'd0) begin bad++; $display("FAIL reset_outstanding: got %0d want 0", outstanding); end
        total++; if (wen !== 1'b1 || r_ready !== 1'b1 || s_strb !== 4'hF) begin
            bad++; $display("FAIL reset_consts: got wen=%b r_ready=%b strb=%h want 1 1 f", wen, r_ready, s_strb);
        end
    endtask

    task automatic test_linear(input string name, input logic [31:0] b, input logic [31:0] s,
                               input int len, input int l, input bit gr, input bit rr,
                               input int stall_at, input int stall_n, input int exp_peak);
        logic [31:0] exp [$];
        int d0, n, stall_left;
        bit stalled;
        lat = l; gnt_rand = gr; ready_rand = rr; ready_low = 0;
        beats.delete(); peak = 0; out_err = 0; req_full = 0; rready_low = 0;
        for (int i = 0; i < len; i++) exp.push_back(exp_beat(b + i * s));
        d0 = done_cnt; stalled = 0; stall_left = stall_n; n = 0;
        start_xfer(b, s, 16'(len));
        while (done_cnt == d0 && n < 3000) begin
            @(negedge clk); #1;
            n++;
            if (!stalled && stall_n > 0 && beats.size() >= stall_at) begin
                stalled = 1; ready_low = 1;
            end
            if (stalled && ready_low) begin
                if (stall_left == 0) ready_low = 0; else stall_left--;
            end
        end
        ready_low = 0;
        total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL %s done_pulses: got %0d want 1", name, done_cnt - d0); end
        total++; if (beats.size() != len) begin bad++; $display("FAIL %s beat_count: got %0d want %0d", name, beats.size(), len); end
        for (int i = 0; i < len && i < beats.size(); i++) begin
            total++;
            if (beats[i] !== exp[i]) begin bad++; $display("FAIL %s beat%0d: got %h want %h", name, i, beats[i], exp[i]); end
        end
        total++; if (done_cyc != last_hs + 1) begin bad++; $display("FAIL %s done_timing: got cycle %0d want %0d", name, done_cyc, last_hs + 1); end
        total++; if (out_err != 0) begin bad++; $display("FAIL %s outstanding_track: got %0d bad cycles want 0", name, out_err); end
        total++; if (req_full != 0) begin bad++; $display("FAIL %s req_at_full: got %0d cycles want 0", name, req_full); end
        total++; if (rready_low != 0) begin bad++; $display("FAIL %s r_ready_low: got %0d cycles want 0", name, rready_low); end
        if (exp_peak >= 0) begin
            total++; if (peak != exp_peak) begin bad++; $display("FAIL %s peak_outstanding: got %0d want %0d", name, peak, exp_peak); end
        end
        total++; if (ready_start !== 1'b1) begin bad++; $display("FAIL %s idle_after: got %b want 1", name, ready_start); end
    endtask

    task automatic test_clear;
        logic [31:0] exp [$];
        int g0, n, d0;
        lat = 6; gnt_rand = 0; ready_rand = 0; ready_low = 1;
        out_err = 0;
        g0 = grant_cnt; gnt_limit = g0 + 3;
        start_xfer(32'h300, 32'd4, 16'd8);
        n = 0;
        while (grant_cnt < g0 + 3 && n < 50) begin @(negedge clk); #1; n++; end
        total++; if (grant_cnt != g0 + 3) begin bad++; $display("FAIL clear_setup_grants: got %0d want 3", grant_cnt - g0); end
        clear = 1'b1;
        @(negedge clk); #1;
        clear = 1'b0;
        total++; if (outstanding !== 3'd0 || ready_start !== 1'b1) begin
            bad++; $display("FAIL clear_flush: got outstanding=%0d ready_start=%b want 0 1", outstanding, ready_start);
        end
        gnt_limit = 32'h7fffffff; ready_low = 0; beats.delete();
        exp.push_back(exp_beat(32'h200)); exp.push_back(exp_beat(32'h204));
        d0 = done_cnt;
        start_xfer(32'h200, 32'd4, 16'd2);
        n = 0;
        while (done_cnt == d0 && n < 200) begin @(negedge clk); #1; n++; end
        total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL clear_restart_done: got %0d want 1", done_cnt - d0); end
        total++; if (beats.size() != 2) begin bad++; $display("FAIL clear_beat_count: got %0d want 2", beats.size()); end
        for (int i = 0; i < 2 && i < beats.size(); i++) begin
            total++;
            if (beats[i] !== exp[i]) begin bad++; $display("FAIL clear_beat%0d: got %h want %h", i, beats[i], exp[i]); end
        end
        total++; if (out_err != 0) begin bad++; $display("FAIL clear_outstanding_track: got %0d bad cycles want 0", out_err); end
        total++; if (pend.size() != 0) begin bad++; $display("FAIL clear_mem_pending: got %0d want 0", pend.size()); end
    endtask

    task automatic test_zero_len;
        int r0, d0;
        r0 = req_seen; d0 = done_cnt;
        start_xfer(32'h400, 32'd4, 16'd0);
        total++; if (done_cnt != d0 + 1 || done_cyc != start_cyc) begin
            bad++; $display("FAIL zero_len_done: got pulses=%0d at %0d want 1 at %0d", done_cnt - d0, done_cyc, start_cyc);
        end
        repeat (10) @(negedge clk);
        #1;
        total++; if (req_seen != r0) begin bad++; $display("FAIL zero_len_req: got %0d req cycles want 0", req_seen - r0); end
        total++; if (done_cnt != d0 + 1) begin bad++; $display("FAIL zero_len_extra_done: got %0d want 1", done_cnt - d0); end
        total++; if (ready_start !== 1'b1) begin bad++; $display("FAIL zero_len_idle: got %b want 1", ready_start); end
    endtask

    task automatic test_random;
        logic [31:0] b, s;
        int len, l;
        for (int t = 0; t < 4; t++) begin
            b   = $urandom & 32'h0000_0FFF;
            s   = 32'($urandom_range(0, 40)) - 32'd20;
            len = $urandom_range(1, 12);
            l   = $urandom_range(1, 5);
            test_linear($sformatf("random%0d", t), b, s, len, l, 1'b1, 1'b1, 0, 0, -1);
        end
    endtask

    initial begin
        rst_n = 1'b0; clear = 1'b0; enable = 1'b1; req_start = 1'b0;
        base = '0; stride = '0; tot_len = '0;
        gnt = 1'b0; r_valid = 1'b0; r_data = '0; s_ready = 1'b1;
        repeat (3) @(negedge clk);
        #1 rst_n = 1'b1;
        test_reset;
        test_linear("basic", 32'h100, 32'd4, 8, 1, 1'b0, 1'b0, 0, 0, -1);
        test_linear("outstanding", 32'h180, 32'd4, 8, 6, 1'b0, 1'b0, 0, 0, 4);
        mem[32'h100] = 32'h3322_1100;
        mem[32'h104] = 32'h7766_5544;
        test_linear("misaligned", 32'h101, 32'd4, 2, 1, 1'b0, 1'b0, 0, 0, -1);
        total++; if (beats.size() < 1 || beats[0] !== 32'h4433_2211) begin
            bad++; $display("FAIL misaligned_beat0: got %h want 44332211", beats.size() > 0 ? beats[0] : 32'hx);
        end
        test_linear("backpressure", 32'h500, 32'd4, 10, 2, 1'b0, 1'b0, 3, 20, 4);
        test_clear;
        test_zero_len;
        test_random;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
